bsg_chip_noc_wh_packet_arbiter: RTL

//  Packet-atomic round-robin arbiter sharing one ready/valid wormhole link among num_in_p

---
 rtl/bsg_chip_noc_wh_packet_arbiter_pkg.sv | 24 ++
 rtl/bsg_chip_noc_wh_packet_arbiter_if.sv | 30 +++
 rtl/bsg_chip_noc_wh_packet_arbiter_rr_pick.sv | 31 +++
 rtl/bsg_chip_noc_wh_packet_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/bsg_chip_noc_wh_packet_arbiter_pkg.sv
// Shared wormhole link constants, header flit layout and arbiter state encoding.
// Arbiter parameter defaults are taken from here at instantiation.
package bsg_chip_noc_wh_packet_arbiter_pkg;

  localparam int wh_num_in_gp        = 2;
  localparam int wh_flit_width_gp    = 32;
  localparam int wh_cord_width_gp    = 8;
  localparam int wh_len_width_gp     = 4;
  localparam int wh_payload_width_gp = wh_flit_width_gp - wh_cord_width_gp - wh_len_width_gp;

  // Header flit: cord in the low bits, len (body flit count) directly above it.
  typedef struct packed {
    logic [wh_payload_width_gp-1:0] payload;
    logic [wh_len_width_gp-1:0]     len;
    logic [wh_cord_width_gp-1:0]    cord;
  } wh_header_s;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_hold = 2'd1,
    e_body = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bsg_chip_noc_wh_packet_arbiter_if.sv
// Ready/valid bundle between the requesting links and the shared wormhole link.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface bsg_chip_noc_wh_packet_arbiter_if
  import bsg_chip_noc_wh_packet_arbiter_pkg::*;
#(
  parameter int num_in_p     = wh_num_in_gp,
  parameter int flit_width_p = wh_flit_width_gp
);
  localparam int lg_w = $clog2(num_in_p);

  logic [num_in_p-1:0]              in_v_i;
  logic [num_in_p*flit_width_p-1:0] in_data_i;
  logic [num_in_p-1:0]              in_ready_and_o;
  logic                             out_v_o;
  logic [flit_width_p-1:0]          out_data_o;
  logic                             out_ready_and_i;
  logic [lg_w-1:0]                  grant_id_o;
  logic                             locked_o;

  modport master (
    input  in_v_i, in_data_i, out_ready_and_i,
    output in_ready_and_o, out_v_o, out_data_o, grant_id_o, locked_o
  );

  modport slave (
    output in_v_i, in_data_i, out_ready_and_i,
    input  in_ready_and_o, out_v_o, out_data_o, grant_id_o, locked_o
  );

endinterface

// File: rtl/bsg_chip_noc_wh_packet_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of v at or after ptr, wrapping.
// Returns the winner one-hot (all zero when nothing is valid) and its index.
module bsg_chip_noc_rr_pick #(
  parameter  int num_in_p = 2,
  localparam int lg_w     = $clog2(num_in_p)
) (
  input  logic [num_in_p-1:0] v,
  input  logic [lg_w-1:0]     ptr,
  output logic [num_in_p-1:0] one_hot,
  output logic [lg_w-1:0]     idx
);

  int  j;
  logic found;

  always_comb begin
    one_hot = '0;
    idx     = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < num_in_p; i++) begin
      j = (int'(ptr) + i) % num_in_p;
      if (!found && v[j]) begin
        found      = 1'b1;
        idx        = lg_w'(j);
        one_hot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_chip_noc_wh_packet_arbiter.sv
// Packet-atomic round-robin arbiter for a shared wormhole link. Flits pass through
// combinationally; only the grant, body counter and round-robin pointer are stored.
module bsg_chip_noc_wh_packet_arbiter
  import bsg_chip_noc_wh_packet_arbiter_pkg::*;
#(
  parameter int num_in_p     = wh_num_in_gp,
  parameter int flit_width_p = wh_flit_width_gp,
  parameter int cord_width_p = wh_cord_width_gp,
  parameter int len_width_p  = wh_len_width_gp
) (
  input logic clk_i,
  input logic reset_i,
  bsg_chip_noc_wh_packet_arbiter_if.master link
);

  localparam int lg_w = $clog2(num_in_p);

  arb_state_e              state_r, state_n;
  logic [lg_w-1:0]         ptr_r, ptr_n;
  logic [lg_w-1:0]         gnt_r, gnt_n;
  logic [len_width_p-1:0]  cnt_r, cnt_n;

  logic [num_in_p-1:0]     pick_oh;
  logic [lg_w-1:0]         pick_idx;
  logic                    pick_found;
  logic [lg_w-1:0]         sel;
  logic                    sel_v;
  logic [flit_width_p-1:0] sel_data;
  logic [len_width_p-1:0]  hdr_len;
  logic                    fire;

  function automatic logic [lg_w-1:0] next_idx(input logic [lg_w-1:0] i);
    return (int'(i) == num_in_p - 1) ? '0 : i + lg_w'(1);
  endfunction

  bsg_chip_noc_rr_pick #(
    .num_in_p(num_in_p)
  ) pick (
    .v       (link.in_v_i),
    .ptr     (ptr_r),
    .one_hot (pick_oh),
    .idx     (pick_idx)
  );

  assign pick_found = |pick_oh;

  // Selection depends only on state and input valids, never on the downstream ready.
  always_comb begin
    sel      = (state_r == e_idle) ? pick_idx : gnt_r;
    sel_v    = (state_r == e_idle) ? pick_found : link.in_v_i[sel];
    sel_data = link.in_data_i[int'(sel)*flit_width_p +: flit_width_p];
  end

  assign hdr_len = sel_data[cord_width_p +: len_width_p];
  assign fire    = sel_v & link.out_ready_and_i;

  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    gnt_n   = gnt_r;
    cnt_n   = cnt_r;
    unique case (state_r)
      e_idle: begin
        if (pick_found) begin
          if (!fire) begin
            state_n = e_hold;
            gnt_n   = pick_idx;
          end else if (hdr_len == '0) begin
            ptr_n = next_idx(pick_idx);
          end else begin
            state_n = e_body;
            gnt_n   = pick_idx;
            cnt_n   = hdr_len;
          end
        end
      end
      e_hold: begin
        if (fire) begin
          if (hdr_len == '0) begin
            state_n = e_idle;
            ptr_n   = next_idx(gnt_r);
          end else begin
            state_n = e_body;
            cnt_n   = hdr_len;
          end
        end
      end
      e_body: begin
        // cnt_r holds the body flits still owed; it never steps below 1 here.
        if (fire) begin
          if (cnt_r <= len_width_p'(1)) begin
            state_n = e_idle;
            ptr_n   = next_idx(gnt_r);
          end else begin
            cnt_n = cnt_r - len_width_p'(1);
          end
        end
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      ptr_r   <= '0;
      gnt_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      gnt_r   <= gnt_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    link.in_ready_and_o = '0;
    if (!reset_i && sel_v) link.in_ready_and_o[sel] = link.out_ready_and_i;
  end

  assign link.out_v_o    = !reset_i && sel_v;
  assign link.out_data_o = sel_data;
  assign link.grant_id_o = reset_i ? '0 : sel;
  assign link.locked_o   = !reset_i && (state_r == e_body);

endmodule
